// File: rtl/pdec_pkg.sv
// pdec_pkg: shared defaults, output-stage state type and index-to-one-hot decode.
// Contents:
//   IN_W_D / OUT_W_D  default index and one-hot widths
//   ost_t             output register state (empty / holding a word)
//   decode()          (idx, en) -> one-hot word, all-zero when en=0
package pdec_pkg;
    localparam int IN_W_D  = 3;
    localparam int OUT_W_D = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ost_t;

    function automatic logic [OUT_W_D-1:0] decode(input logic [IN_W_D-1:0] idx, input logic en);
        return en ? (OUT_W_D'(1) << idx) : '0;
    endfunction
endpackage

// File: rtl/pdec_fifo.sv
// pdec_fifo: DEPTH-entry synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers and count only)
//   push, din    write request and data; ignored while full
//   pop, dout    read request and head data; ignored while empty
//   full, empty  occupancy flags decoded from the registered count
module pdec_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/pdec8_stream.sv
// pdec8_stream: streaming 3-to-8 decoder with input buffer, output register and sticky delivery mask.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_idx/in_en  index input handshake; in_en=0 yields an all-zero word
//   out_valid/out_ready             output handshake
//   out_onehot, out_idx             decoded word and the index it came from
//   mask, mask_clr                  sticky OR of delivered words and its synchronous clear
//   ovf                             sticky: a delivered word hit a bit already in mask
module pdec8_stream
    import pdec_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [IN_W-1:0]  out_idx,
    output logic [OUT_W-1:0] mask,
    input  logic             mask_clr,
    output logic             ovf
);
    localparam int W = IN_W + 1;

    logic             push, pop, full, empty, xfer;
    logic [W-1:0]     head;
    logic [OUT_W-1:0] head_oh;
    ost_t             state, state_n;

    // in_ready depends only on the registered buffer count, never on out_ready.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head_oh  = OUT_W'(decode(IN_W_D'(head[W-1:1]), head[0]));

    pdec_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({in_idx, in_en}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_n;
    end

    // A pop always refills the register; otherwise a transfer empties it.
    always_comb begin
        state_n = pop ? ST_FULL : (xfer ? ST_EMPTY : state);
    end

    always_comb begin
        out_valid = state == ST_FULL;
        xfer      = out_valid && out_ready;
        pop       = !empty && (!out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_onehot <= '0;
            out_idx    <= '0;
        end else if (pop) begin
            out_onehot <= head_oh;
            out_idx    <= head[W-1:1];
        end
    end

    // Clear takes effect before the same-cycle transfer is merged in, so the
    // transferred word survives a clear and cannot raise ovf against stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            ovf  <= 1'b0;
        end else begin
            mask <= (mask_clr ? '0 : mask) | (xfer ? out_onehot : '0);
            ovf  <= !mask_clr && (ovf || (xfer && |(mask & out_onehot)));
        end
    end
endmodule

// File: tb/tb_pdec8_stream.sv
// tb_pdec8_stream: order-preserving queue model plus directed literal checks for pdec8_stream.
module tb_pdec8_stream;
    localparam int DEPTH = 2;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [2:0] in_idx = '0;
    logic       in_en = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [7:0] out_onehot;
    logic [2:0] out_idx;
    logic [7:0] mask;
    logic       mask_clr = 0;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    pdec8_stream #(.IN_W(3), .OUT_W(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .mask       (mask),
        .mask_clr   (mask_clr),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic       en;
        int         edge_no;
    } word_t;

    word_t      q[$];
    int         cyc = 0;
    logic [7:0] mask_m = '0;
    logic       ovf_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A word is visible one edge after the edge that accepted it.
    function automatic bit exp_valid();
        return q.size() > 0 && q[0].edge_no < cyc;
    endfunction

    function automatic bit exp_ready();
        return (int'(q.size()) - int'(exp_valid())) < DEPTH;
    endfunction

    function automatic int penc(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) if (w[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit         xf, ac;
        logic [7:0] oh;
        if (!rst_n) begin
            q.delete();
            cyc    = 0;
            mask_m = '0;
            ovf_m  = 0;
        end else begin
            xf = exp_valid() && out_ready;
            ac = in_valid && exp_ready();
            cyc++;
            if (xf) begin
                oh = q[0].en ? (8'd1 << q[0].idx) : 8'd0;
                if (mask_clr) begin
                    mask_m = oh;
                    ovf_m  = 0;
                end else begin
                    ovf_m  = ovf_m | (|(mask_m & oh));
                    mask_m = mask_m | oh;
                end
                void'(q.pop_front());
            end else if (mask_clr) begin
                mask_m = '0;
                ovf_m  = 0;
            end
            if (ac) q.push_back('{idx: in_idx, en: in_en, edge_no: cyc});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 1);
            chk("rst_out_valid", {31'd0, out_valid}, 0);
            chk("rst_onehot", {24'd0, out_onehot}, 0);
            chk("rst_mask", {24'd0, mask}, 0);
            chk("rst_ovf", {31'd0, ovf}, 0);
        end else begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, exp_valid()});
            if (exp_valid()) begin
                chk("m_onehot", {24'd0, out_onehot}, q[0].en ? (32'd1 << q[0].idx) : 32'd0);
                chk("m_out_idx", {29'd0, out_idx}, {29'd0, q[0].idx});
                if (q[0].en) chk("m_roundtrip", penc(out_onehot), {29'd0, out_idx});
            end
            chk("m_mask", {24'd0, mask}, {24'd0, mask_m});
            chk("m_ovf", {31'd0, ovf}, {31'd0, ovf_m});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] i, input logic e);
        bit ok = 0;
        in_valid = 1;
        in_idx   = i;
        in_en    = e;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 0;
        chk("push_accept", {31'd0, ok}, 1);
    endtask

    initial begin
        repeat (2) step();
        chk("t1_in_ready", {31'd0, in_ready}, 1);
        chk("t1_out_valid", {31'd0, out_valid}, 0);
        chk("t1_onehot", {24'd0, out_onehot}, 32'h00);
        chk("t1_mask", {24'd0, mask}, 32'h00);
        chk("t1_ovf", {31'd0, ovf}, 0);
        rst_n = 1;
        step();

        out_ready = 1;
        push(3'd5, 1);
        step();
        chk("t2_valid", {31'd0, out_valid}, 1);
        chk("t2_onehot", {24'd0, out_onehot}, 32'h20);
        chk("t2_idx", {29'd0, out_idx}, 5);
        step();
        chk("t2_mask", {24'd0, mask}, 32'h20);

        mask_clr = 1;
        step();
        mask_clr = 0;
        for (int i = 0; i < 8; i++) push(3'(i), 1);
        step();
        chk("t3_last_onehot", {24'd0, out_onehot}, 32'h80);
        repeat (3) step();
        chk("t3_mask", {24'd0, mask}, 32'hFF);
        chk("t3_ovf", {31'd0, ovf}, 0);

        out_ready = 0;
        push(3'd3, 1);
        push(3'd6, 1);
        push(3'd1, 1);
        in_valid = 1;
        in_idx   = 3'd0;
        in_en    = 1;
        step();
        chk("t4_full", {31'd0, in_ready}, 0);
        chk("t4_hold", {24'd0, out_onehot}, 32'h08);
        step();
        chk("t4_hold2", {24'd0, out_onehot}, 32'h08);
        in_valid = 0;
        out_ready = 1;
        step();
        chk("t4_second", {24'd0, out_onehot}, 32'h40);
        step();
        chk("t4_third", {24'd0, out_onehot}, 32'h02);
        step();
        chk("t4_drained", {31'd0, out_valid}, 0);

        mask_clr = 1;
        step();
        mask_clr = 0;
        push(3'd2, 1);
        push(3'd2, 1);
        repeat (3) step();
        chk("t5_mask", {24'd0, mask}, 32'h04);
        chk("t5_ovf", {31'd0, ovf}, 1);
        push(3'd4, 0);
        step();
        chk("t5_en0_valid", {31'd0, out_valid}, 1);
        chk("t5_en0_onehot", {24'd0, out_onehot}, 32'h00);
        chk("t5_en0_idx", {29'd0, out_idx}, 4);
        step();
        chk("t5_en0_mask", {24'd0, mask}, 32'h04);
        push(3'd7, 1);
        step();
        mask_clr = 1;
        step();
        mask_clr = 0;
        chk("t5_clr_mask", {24'd0, mask}, 32'h80);
        chk("t5_clr_ovf", {31'd0, ovf}, 0);

        out_ready = 0;
        push(3'd1, 1);
        push(3'd2, 1);
        push(3'd3, 1);
        chk("t6_valid_pre", {31'd0, out_valid}, 1);
        chk("t6_full_pre", {31'd0, in_ready}, 0);
        #2;
        rst_n = 0;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 0);
        chk("t6_onehot", {24'd0, out_onehot}, 32'h00);
        chk("t6_idx", {29'd0, out_idx}, 0);
        chk("t6_mask", {24'd0, mask}, 32'h00);
        chk("t6_ovf", {31'd0, ovf}, 0);
        chk("t6_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1;
        out_ready = 1;
        repeat (3) step();
        chk("t6_no_stale", {31'd0, out_valid}, 0);
        chk("t6_ready_after", {31'd0, in_ready}, 1);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
